alu_pipe: RTL

- Parametrised, pipelined successor of the team's combinational 10-bit signed ALU.
- Keeps the same eight operations and the same {NEG,POS,ZERO,OVF} flag vector.
- Adds generic width, an optional saturating mode for ADD/SUB, valid/ready handshakes on input and output, and a sticky overflow register.
- Sits between the operand sequencer and the result writeback in the datapath.

---
 rtl/alu_pipe.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - two-stage pipelined signed ALU with valid/ready handshakes
// Stage 1 holds the accepted operands; stage 2 computes and holds {result, flag}.
module alu_pipe #(
  parameter int WIDTH  = 10,
  parameter bit SAT_EN = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_arg0,
  input  logic [WIDTH-1:0] i_arg1,
  input  logic [2:0]       i_oper,
  input  logic             i_sat,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_result,
  output logic [3:0]       o_flag,
  input  logic             i_clr_sticky,
  output logic             o_ovf_sticky
);

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_MAX  = 3'd2,
    OP_MIN  = 3'd3,
    OP_AND  = 3'd4,
    OP_ORR  = 3'd5,
    OP_XOR  = 3'd6,
    OP_XNOR = 3'd7
  } op_e;

  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] a_q, b_q;
  op_e              oper_q;
  logic             sat_q;

  logic             o_valid_q, o_valid_d;
  logic [WIDTH-1:0] result_q;
  logic [3:0]       flag_q;
  logic             sticky_q, sticky_d;

  logic             out_load;
  logic             accept;

  logic [WIDTH-1:0] sum, diff, raw, result_d;
  logic             add_ovf, sub_ovf, ovf_d, a_ge_b;
  logic             neg_d, zero_d, pos_d;

  // Stage 1 may refill in the same cycle it drains into the output register.
  assign out_load = s1_valid_q & (~o_valid_q | i_ready);
  assign o_ready  = ~s1_valid_q | ~o_valid_q | i_ready;
  assign accept   = i_valid & o_ready;

  assign s1_valid_d = accept | (s1_valid_q & ~out_load);
  assign o_valid_d  = out_load | (o_valid_q & ~i_ready);

  assign sum     = a_q + b_q;
  assign diff    = a_q - b_q;
  assign add_ovf = (a_q[WIDTH-1] == b_q[WIDTH-1]) & (sum[WIDTH-1] != a_q[WIDTH-1]);
  assign sub_ovf = (a_q[WIDTH-1] != b_q[WIDTH-1]) & (diff[WIDTH-1] != a_q[WIDTH-1]);
  assign a_ge_b  = $signed(a_q) >= $signed(b_q);

  always_comb begin
    raw   = '0;
    ovf_d = 1'b0;
    case (oper_q)
      OP_ADD: begin
        raw   = sum;
        ovf_d = add_ovf;
      end
      OP_SUB: begin
        raw   = diff;
        ovf_d = sub_ovf;
      end
      OP_MAX:  raw = a_ge_b ? a_q : b_q;
      OP_MIN:  raw = ($signed(a_q) <= $signed(b_q)) ? a_q : b_q;
      OP_AND:  raw = a_q & b_q;
      OP_ORR:  raw = a_q | b_q;
      OP_XOR:  raw = a_q ^ b_q;
      OP_XNOR: raw = ~(a_q ^ b_q);
      default: raw = '0;
    endcase
  end

  // Saturation clamps toward the sign of operand A, which is the true overflow direction.
  always_comb begin
    result_d = raw;
    if (SAT_EN && sat_q && ovf_d) begin
      result_d = a_q[WIDTH-1] ? SMIN : SMAX;
    end
  end

  assign neg_d  = result_d[WIDTH-1];
  assign zero_d = (result_d == '0);
  assign pos_d  = ~neg_d & ~zero_d;

  assign sticky_d = (out_load & ovf_d) | (sticky_q & ~i_clr_sticky);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid_q <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      oper_q     <= OP_ADD;
      sat_q      <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      if (accept) begin
        a_q    <= i_arg0;
        b_q    <= i_arg1;
        oper_q <= op_e'(i_oper);
        sat_q  <= i_sat;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid_q <= 1'b0;
      result_q  <= '0;
      flag_q    <= 4'b0000;
      sticky_q  <= 1'b0;
    end else begin
      o_valid_q <= o_valid_d;
      sticky_q  <= sticky_d;
      if (out_load) begin
        result_q <= result_d;
        flag_q   <= {neg_d, pos_d, zero_d, ovf_d};
      end
    end
  end

  assign o_valid      = o_valid_q;
  assign o_result     = result_q;
  assign o_flag       = flag_q;
  assign o_ovf_sticky = sticky_q;

endmodule
